// File: rtl/nand_fault_injector.sv
// nand_fault_injector: seed-driven bit-error injector on the NAND read-data path.
// The injector sits between the flash DIO capture and the ECC decoder.
// Each arm builds a small fault table. The table holds either LFSR-random
// positions inside a byte window, or one directed position. The injector then
// corrupts those bits on the next page and disarms.
// Optional build macro: FI_STUCK_AT_EN adds stuck_val_i. Matched bits are then
// forced to that value instead of being flipped.
module nand_fault_injector #(
  parameter int DATA_W     = 8,
  parameter int PAGE_BYTES = 2112,
  parameter int MAX_FAULTS = 16,
  parameter int ADDR_W     = 12
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic                             arm_i,
  input  logic                             mode_i,
  input  logic [31:0]                      seed_i,
  input  logic [$clog2(MAX_FAULTS+1)-1:0]  fault_num_i,
  input  logic [ADDR_W-1:0]                lo_i,
  input  logic [ADDR_W-1:0]                hi_i,
  input  logic [ADDR_W-1:0]                dir_byte_i,
  input  logic [$clog2(DATA_W)-1:0]        dir_bit_i,
`ifdef FI_STUCK_AT_EN
  input  logic                             stuck_val_i,
`endif
  input  logic                             s_valid_i,
  input  logic                             s_sop_i,
  input  logic [DATA_W-1:0]                s_data_i,
  output logic                             m_valid_o,
  output logic [DATA_W-1:0]                m_data_o,
  output logic                             m_fault_o,
  output logic                             busy_o,
  output logic                             armed_o,
  output logic                             done_o,
  output logic                             cfg_err_o,
  output logic [$clog2(MAX_FAULTS+1)-1:0]  inj_cnt_o
);

  localparam int CNT_W = $clog2(MAX_FAULTS + 1);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int unsigned ADDR_WU = ADDR_W;
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;  // x^32+x^22+x^2+x+1
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(PAGE_BYTES - 1);
  localparam logic [ADDR_W:0]   PAGE_N    = (ADDR_W + 1)'(PAGE_BYTES);
  localparam logic [CNT_W-1:0]  MAX_N     = CNT_W'(MAX_FAULTS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_ARMED,
    S_INJECT
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       lfsr_q, lfsr_d, lfsr_nxt;

  // Latched arm configuration
  logic              mode_q;
  logic [CNT_W-1:0]  target_q;
  logic [ADDR_W-1:0] lo_q;
  logic [ADDR_W-1:0] span_m1_q;
  logic [ADDR_W-1:0] cmask_q;
  logic [ADDR_W-1:0] dbyte_q;
  logic [BIT_W-1:0]  dbit_q;
  logic [ADDR_W-1:0] span_fill;

  // Fault table
  logic              tbl_vld_q  [MAX_FAULTS];
  logic [ADDR_W-1:0] tbl_byte_q [MAX_FAULTS];
  logic [BIT_W-1:0]  tbl_bit_q  [MAX_FAULTS];
  logic [CNT_W-1:0]  ent_cnt_q;

  // Streaming side
  logic [ADDR_W-1:0] idx_q, idx_d, cur_idx;
  logic [CNT_W-1:0]  inj_cnt_q, inj_cnt_d;
  logic              m_valid_q, m_fault_q, fault_d;
  logic [DATA_W-1:0] m_data_q, out_d, mask;
  logic              last_q, done_q, cfg_err_q;

  // FSM decode outputs
  logic              arm_ok, cfg_err_d, wr_en, inj_act, page_end;
  logic [ADDR_W-1:0] wr_byte, cand;
  logic [BIT_W-1:0]  wr_bit;

  // Candidate mask: fill every bit below the MSB of (hi - lo) so cand covers span
  always_comb begin
    span_fill = hi_i - lo_i;
    for (int unsigned s = 1; s < ADDR_WU; s = s << 1) begin
      span_fill = span_fill | (span_fill >> s);
    end
  end

  // Galois LFSR step and current rejection-sampling candidate
  always_comb begin
    lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    cand     = lfsr_q[ADDR_W-1:0] & cmask_q;
  end

  // Byte index and injection window.
  // The SOP byte that leaves ARMED is already index 0 of the injected page.
  always_comb begin
    cur_idx  = s_sop_i ? '0 : idx_q;
    inj_act  = s_valid_i && ((state_q == S_INJECT) || (state_q == S_ARMED && s_sop_i));
    page_end = inj_act && (cur_idx == LAST_IDX);
    idx_d    = inj_act ? cur_idx + 1'b1 : idx_q;
  end

  // Next-state logic: arm validation, table generation, page tracking
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    arm_ok    = 1'b0;
    cfg_err_d = 1'b0;
    wr_en     = 1'b0;
    wr_byte   = '0;
    wr_bit    = '0;
    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          if (!mode_i && ((lo_i > hi_i) || ({1'b0, hi_i} >= PAGE_N))) begin
            cfg_err_d = 1'b1;
          end else begin
            arm_ok  = 1'b1;
            lfsr_d  = (seed_i == 32'h0) ? 32'h1 : seed_i;
            state_d = S_GEN;
          end
        end
      end
      S_GEN: begin
        lfsr_d = lfsr_nxt;
        if (mode_q) begin
          wr_en   = 1'b1;
          wr_byte = dbyte_q;
          wr_bit  = dbit_q;
          state_d = S_ARMED;
        end else if (ent_cnt_q == target_q) begin
          state_d = S_ARMED;
        end else if (cand <= span_m1_q) begin
          wr_en   = 1'b1;
          wr_byte = lo_q + cand;
          wr_bit  = lfsr_q[31 -: BIT_W];
          if (ent_cnt_q + CNT_W'(1) == target_q) begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (inj_act) begin
          state_d = page_end ? S_IDLE : S_INJECT;
        end
      end
      S_INJECT: begin
        if (page_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and LFSR registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      lfsr_q  <= 32'h1;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Configuration latched on an accepted arm
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_q    <= 1'b0;
      target_q  <= '0;
      lo_q      <= '0;
      span_m1_q <= '0;
      cmask_q   <= '0;
      dbyte_q   <= '0;
      dbit_q    <= '0;
    end else if (arm_ok) begin
      mode_q    <= mode_i;
      target_q  <= (fault_num_i > MAX_N) ? MAX_N : fault_num_i;
      lo_q      <= lo_i;
      span_m1_q <= hi_i - lo_i;
      cmask_q   <= span_fill;
      dbyte_q   <= dir_byte_i;
      dbit_q    <= dir_bit_i;
    end
  end

  // Fault table: cleared on arm, appended one entry per accepted candidate
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ent_cnt_q <= '0;
      for (int unsigned i = 0; i < MAX_FAULTS; i++) begin
        tbl_vld_q[i]  <= 1'b0;
        tbl_byte_q[i] <= '0;
        tbl_bit_q[i]  <= '0;
      end
    end else if (arm_ok) begin
      ent_cnt_q <= '0;
      for (int unsigned i = 0; i < MAX_FAULTS; i++) begin
        tbl_vld_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      ent_cnt_q <= ent_cnt_q + 1'b1;
      for (int unsigned i = 0; i < MAX_FAULTS; i++) begin
        if (ent_cnt_q == CNT_W'(i)) begin
          tbl_vld_q[i]  <= 1'b1;
          tbl_byte_q[i] <= wr_byte;
          tbl_bit_q[i]  <= wr_bit;
        end
      end
    end
  end

  // Per-byte bit mask from matching table entries and the modified byte
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_FAULTS; i++) begin
      if (tbl_vld_q[i] && (tbl_byte_q[i] == cur_idx)) begin
`ifdef FI_STUCK_AT_EN
        mask = mask | (DATA_W'(1) << tbl_bit_q[i]);
`else
        mask = mask ^ (DATA_W'(1) << tbl_bit_q[i]);
`endif
      end
    end
    if (!inj_act) begin
      mask = '0;
    end
`ifdef FI_STUCK_AT_EN
    out_d = stuck_val_i ? (s_data_i | mask) : (s_data_i & ~mask);
`else
    out_d = s_data_i ^ mask;
`endif
    fault_d   = (out_d != s_data_i);
    inj_cnt_d = inj_cnt_q;
    if (arm_ok) begin
      inj_cnt_d = '0;
    end else if (fault_d && (inj_cnt_q != CNT_SAT)) begin
      inj_cnt_d = inj_cnt_q + 1'b1;
    end
  end

  // One-cycle datapath register, index tracking, and status pulses
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_fault_q <= 1'b0;
      idx_q     <= '0;
      inj_cnt_q <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      m_valid_q <= s_valid_i;
      m_data_q  <= out_d;
      m_fault_q <= fault_d;
      idx_q     <= idx_d;
      inj_cnt_q <= inj_cnt_d;
      last_q    <= page_end;
      done_q    <= last_q;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_fault_o = m_fault_q;
  assign inj_cnt_o = inj_cnt_q;
  assign done_o    = done_q;
  assign cfg_err_o = cfg_err_q;
  assign busy_o    = (state_q == S_GEN);
  assign armed_o   = (state_q == S_ARMED) || (state_q == S_INJECT);

endmodule

// File: tb/tb_nand_fault_injector.sv
// Directed-vector bench for nand_fault_injector.
// A small table model derived from the LFSR description predicts each output byte.
module tb_nand_fault_injector;

  logic        HCLK;
  logic        HRESETn;
  logic        arm_i;
  logic        mode_i;
  logic [31:0] seed_i;
  logic [4:0]  fault_num_i;
  logic [11:0] lo_i;
  logic [11:0] hi_i;
  logic [11:0] dir_byte_i;
  logic [2:0]  dir_bit_i;
`ifdef FI_STUCK_AT_EN
  logic        stuck_val_i;
`endif
  logic        s_valid_i;
  logic        s_sop_i;
  logic [7:0]  s_data_i;
  logic        m_valid_o;
  logic [7:0]  m_data_o;
  logic        m_fault_o;
  logic        busy_o;
  logic        armed_o;
  logic        done_o;
  logic        cfg_err_o;
  logic [4:0]  inj_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  logic [7:0] exp_mask [0:4095];
  logic [7:0] cap      [0:2111];
  logic [7:0] cap_a    [0:2111];

  nand_fault_injector #(
    .DATA_W(8), .PAGE_BYTES(2112), .MAX_FAULTS(16), .ADDR_W(12)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .arm_i(arm_i), .mode_i(mode_i),
    .seed_i(seed_i), .fault_num_i(fault_num_i), .lo_i(lo_i), .hi_i(hi_i),
    .dir_byte_i(dir_byte_i), .dir_bit_i(dir_bit_i),
`ifdef FI_STUCK_AT_EN
    .stuck_val_i(stuck_val_i),
`endif
    .s_valid_i(s_valid_i), .s_sop_i(s_sop_i), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_fault_o(m_fault_o),
    .busy_o(busy_o), .armed_o(armed_o), .done_o(done_o),
    .cfg_err_o(cfg_err_o), .inj_cnt_o(inj_cnt_o)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  function automatic logic [31:0] lstep(input logic [31:0] v);
    lstep = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic put_bit(input int b, input logic [2:0] bt);
`ifdef FI_STUCK_AT_EN
    exp_mask[b] = exp_mask[b] | (8'(1) << bt);
`else
    exp_mask[b] = exp_mask[b] ^ (8'(1) << bt);
`endif
  endtask

  task automatic build_model(input logic md, input logic [31:0] sd, input logic [4:0] fn,
                             input logic [11:0] lo, input logic [11:0] hi,
                             input logic [11:0] db, input logic [2:0] bt);
    logic [31:0] l;
    int span, k, msk, tgt, cnt, cand, guard;
    for (int i = 0; i < 4096; i++) exp_mask[i] = 8'h00;
    if (md) begin
      put_bit(int'(db), bt);
    end else begin
      l = (sd == 32'h0) ? 32'h1 : sd;
      span = int'(hi) - int'(lo) + 1;
      k = 0;
      while ((1 << k) < span) k++;
      msk = (1 << k) - 1;
      tgt = (fn > 5'd16) ? 16 : int'(fn);
      cnt = 0;
      guard = 0;
      while (cnt < tgt && guard < 100000) begin
        cand = int'(l[11:0]) & msk;
        if (cand < span) begin
          put_bit(int'(lo) + cand, l[31:29]);
          cnt++;
        end
        l = lstep(l);
        guard++;
      end
    end
  endtask

  task automatic arm_cfg(input logic md, input logic [31:0] sd, input logic [4:0] fn,
                         input logic [11:0] lo, input logic [11:0] hi,
                         input logic [11:0] db, input logic [2:0] bt, input logic exp_err);
    int c;
    mode_i = md; seed_i = sd; fault_num_i = fn; lo_i = lo; hi_i = hi;
    dir_byte_i = db; dir_bit_i = bt; arm_i = 1'b1;
    @(posedge HCLK); #1;
    arm_i = 1'b0;
    vectors++;
    if (exp_err) begin
      if ({cfg_err_o, busy_o, armed_o} !== 3'b100) begin
        miscompares++;
        $display("FAIL arm_reject: err/busy/armed=%b want 100", {cfg_err_o, busy_o, armed_o});
      end
      @(posedge HCLK); #1;
      vectors++;
      if ({cfg_err_o, armed_o} !== 2'b00) begin
        miscompares++;
        $display("FAIL arm_reject_pulse: err/armed=%b want 00", {cfg_err_o, armed_o});
      end
    end else begin
      build_model(md, sd, fn, lo, hi, db, bt);
      exp_cnt = 0;
      if ({cfg_err_o, busy_o, armed_o} !== 3'b010) begin
        miscompares++;
        $display("FAIL arm_gen: err/busy/armed=%b want 010", {cfg_err_o, busy_o, armed_o});
      end
      c = 0;
      while (!armed_o && c < 5000) begin
        @(posedge HCLK); #1;
        c++;
      end
      vectors++;
      if ({armed_o, busy_o} !== 2'b10) begin
        miscompares++;
        $display("FAIL arm_ready: armed/busy=%b after %0d cycles want 10", {armed_o, busy_o}, c);
      end
    end
  endtask

  task automatic stream(input int n, input logic [7:0] base, input logic vary, input logic inj);
    logic [7:0] d, m, ed;
    logic ef;
    for (int i = 0; i < n; i++) begin
      d = vary ? (base ^ 8'(i)) : base;
      m = inj ? exp_mask[i] : 8'h00;
`ifdef FI_STUCK_AT_EN
      ed = stuck_val_i ? (d | m) : (d & ~m);
`else
      ed = d ^ m;
`endif
      ef = (ed != d);
      s_valid_i = 1'b1; s_sop_i = (i == 0); s_data_i = d;
      @(posedge HCLK); #1;
      vectors++;
      if ({m_valid_o, m_fault_o, done_o, m_data_o} !== {1'b1, ef, 1'b0, ed}) begin
        miscompares++;
        $display("FAIL stream byte %0d: got v=%b f=%b done=%b d=%h, want v=1 f=%b done=0 d=%h",
                 i, m_valid_o, m_fault_o, done_o, m_data_o, ef, ed);
      end
      cap[i] = m_data_o ^ d;
      if (ef && exp_cnt < 31) exp_cnt++;
    end
    s_valid_i = 1'b0; s_sop_i = 1'b0;
  endtask

  task automatic finish_page(input logic exp_done);
    @(posedge HCLK); #1;
    vectors++;
    if ({done_o, armed_o, inj_cnt_o} !== {exp_done, 1'b0, 5'(exp_cnt)}) begin
      miscompares++;
      $display("FAIL page_end: done=%b armed=%b cnt=%0d want done=%b armed=0 cnt=%0d",
               done_o, armed_o, inj_cnt_o, exp_done, exp_cnt);
    end
    @(posedge HCLK); #1;
    vectors++;
    if (done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: done=%b want 0", done_o);
    end
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    arm_i = 0; mode_i = 0; seed_i = 0; fault_num_i = 0; lo_i = 0; hi_i = 0;
    dir_byte_i = 0; dir_bit_i = 0; s_valid_i = 0; s_sop_i = 0; s_data_i = 0;
`ifdef FI_STUCK_AT_EN
    stuck_val_i = 1'b0;
`endif
    #2;
    vectors++;
    if ({m_valid_o, m_data_o, m_fault_o, busy_o, armed_o, done_o, cfg_err_o, inj_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want all zero",
               {m_valid_o, m_data_o, m_fault_o, busy_o, armed_o, done_o, cfg_err_o, inj_cnt_o});
    end
    #7 HRESETn = 1'b1;
    @(posedge HCLK); #1;
  endtask

  task automatic test_directed;
    arm_cfg(1'b1, 32'h0, 5'd0, 12'd0, 12'd0, 12'd5, 3'd3, 1'b0);
    // a second arm while armed must not touch the table
    mode_i = 1'b1; dir_byte_i = 12'd6; arm_i = 1'b1;
    @(posedge HCLK); #1;
    arm_i = 1'b0;
    vectors++;
    if ({armed_o, busy_o, cfg_err_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL arm_ignored: armed/busy/err=%b want 100", {armed_o, busy_o, cfg_err_o});
    end
    stream(2112, 8'hFF, 1'b0, 1'b1);
    finish_page(1'b1);
  endtask

  task automatic test_random;
    int outside, total, diffs;
    arm_cfg(1'b0, 32'h0000_ACE1, 5'd16, 12'd1024, 12'd2047, 12'd0, 3'd0, 1'b0);
    stream(2112, 8'h5A, 1'b1, 1'b1);
    finish_page(1'b1);
    outside = 0; total = 0;
    for (int i = 0; i < 2112; i++) begin
      cap_a[i] = cap[i];
      if (cap[i] != 8'h00 && (i < 1024 || i > 2047)) outside++;
      total += $countones(cap[i]);
    end
    vectors++;
    if (outside != 0) begin
      miscompares++;
      $display("FAIL window: %0d modified bytes outside 1024..2047, want 0", outside);
    end
`ifndef FI_STUCK_AT_EN
    vectors++;
    if (total > 16 || ((16 - total) % 2) != 0) begin
      miscompares++;
      $display("FAIL popcount: flipped bits %0d, want 16 minus an even number", total);
    end
`endif
    arm_cfg(1'b0, 32'h0000_ACE1, 5'd16, 12'd1024, 12'd2047, 12'd0, 3'd0, 1'b0);
    stream(2112, 8'h5A, 1'b1, 1'b1);
    finish_page(1'b1);
    diffs = 0;
    for (int i = 0; i < 2112; i++) if (cap[i] != cap_a[i]) diffs++;
    vectors++;
    if (diffs != 0) begin
      miscompares++;
      $display("FAIL rerun: %0d bytes differ between identical-seed runs, want 0", diffs);
    end
  endtask

  task automatic test_random_edges;
    // zero seed, single-byte window at the last byte of the page
    arm_cfg(1'b0, 32'h0, 5'd3, 12'd2111, 12'd2111, 12'd0, 3'd0, 1'b0);
    stream(2112, 8'h00, 1'b1, 1'b1);
    finish_page(1'b1);
    // odd span forces rejections; fault_num above table depth clamps to 16
    arm_cfg(1'b0, 32'h1234_5678, 5'd20, 12'd100, 12'd104, 12'd0, 3'd0, 1'b0);
    stream(2112, 8'hA5, 1'b1, 1'b1);
    finish_page(1'b1);
  endtask

  task automatic test_zero_faults;
    arm_cfg(1'b0, 32'hDEAD_BEEF, 5'd0, 12'd0, 12'd2111, 12'd0, 3'd0, 1'b0);
    stream(2112, 8'h3C, 1'b1, 1'b1);
    finish_page(1'b1);
  endtask

  task automatic test_cfg_err;
    arm_cfg(1'b0, 32'h1, 5'd4, 12'd100, 12'd50, 12'd0, 3'd0, 1'b1);
    arm_cfg(1'b0, 32'h1, 5'd4, 12'd0, 12'd2112, 12'd0, 3'd0, 1'b1);
    stream(64, 8'hC3, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_inject;
    int dones;
    arm_cfg(1'b1, 32'h0, 5'd0, 12'd0, 12'd0, 12'd800, 3'd0, 1'b0);
    stream(701, 8'h11, 1'b1, 1'b1);
    HRESETn = 1'b0;
    #1;
    vectors++;
    if ({m_valid_o, m_data_o, m_fault_o, busy_o, armed_o, done_o, cfg_err_o, inj_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got %b want all zero",
               {m_valid_o, m_data_o, m_fault_o, busy_o, armed_o, done_o, cfg_err_o, inj_cnt_o});
    end
    @(posedge HCLK); #3;
    HRESETn = 1'b1;
    exp_cnt = 0;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge HCLK); #1;
      if (done_o) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL no_done_after_reset: done seen %0d times want 0", dones);
    end
    arm_cfg(1'b1, 32'h0, 5'd0, 12'd0, 12'd0, 12'd2111, 3'd7, 1'b0);
    stream(2112, 8'h0F, 1'b1, 1'b1);
    finish_page(1'b1);
  endtask

  task automatic test_sop_restart;
    arm_cfg(1'b1, 32'h0, 5'd0, 12'd0, 12'd0, 12'd3, 3'd0, 1'b0);
    stream(10, 8'h3C, 1'b1, 1'b1);
    stream(2112, 8'h3C, 1'b1, 1'b1);
    finish_page(1'b1);
  endtask

`ifdef FI_STUCK_AT_EN
  task automatic test_stuck;
    stuck_val_i = 1'b0;
    arm_cfg(1'b1, 32'h0, 5'd0, 12'd0, 12'd0, 12'd0, 3'd0, 1'b0);
    stream(2112, 8'h00, 1'b0, 1'b1);
    finish_page(1'b1);
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_random_edges;
    test_zero_faults;
    test_cfg_err;
    test_reset_mid_inject;
    test_sop_restart;
`ifdef FI_STUCK_AT_EN
    test_stuck;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nand_fault_injector.md
Name: nand_fault_injector

Overview:
- Synthesisable, parametrised bit-error injector on the NAND read-data path, between flash DIO capture and the ECC decoder in Top.
- Per arm: builds a table of up to MAX_FAULTS (byte, bit) positions, either random from a seeded LFSR inside a byte window or one directed position.
- On the next page streamed after arming, flips those bits in flight, then disarms.
- Replaces behavioural array poking with a reproducible, seed-driven in-silicon mechanism that works with ECC on or off.

Parameters:
- DATA_W, 8, stream data width (bits).
- PAGE_BYTES, 2112, bytes per page including spare.
- MAX_FAULTS, 16, fault table depth.
- ADDR_W, 12, byte-index width; must satisfy 2^ADDR_W >= PAGE_BYTES.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- arm_i  in  1  one-cycle request to build the table and arm.
- mode_i  in  1  0 = random, 1 = directed.
- seed_i  in  32  LFSR seed, loaded on arm; 0 is replaced by 32'h1.
- fault_num_i  in  $clog2(MAX_FAULTS+1)  faults to generate, random mode.
- lo_i  in  ADDR_W  window low byte index, inclusive.
- hi_i  in  ADDR_W  window high byte index, inclusive.
- dir_byte_i  in  ADDR_W  directed byte index.
- dir_bit_i  in  $clog2(DATA_W)  directed bit index.
- s_valid_i  in  1  input byte valid.
- s_sop_i  in  1  first byte of page, qualified by s_valid_i.
- s_data_i  in  DATA_W  input byte.
- m_valid_o  out  1  output byte valid.
- m_data_o  out  DATA_W  output byte.
- m_fault_o  out  1  current output byte was modified.
- busy_o  out  1  state is GEN.
- armed_o  out  1  state is ARMED or INJECT.
- done_o  out  1  one-cycle pulse at end of injected page.
- cfg_err_o  out  1  one-cycle pulse when arm is rejected.
- inj_cnt_o  out  $clog2(MAX_FAULTS+1)  bytes modified in last page; saturating.

Behaviour:
- Reset: all outputs 0, state IDLE, table cleared, LFSR = 32'h1. Reset mid-operation aborts everything with no done_o.
- Datapath is always a 1-cycle register:
  - m_valid_o = s_valid_i delayed 1.
  - m_data_o = s_data_i XOR mask, where mask is the XOR of one-hot(bit) over all valid table entries whose byte equals the current index.
  - Duplicate entries therefore cancel; this is intended.
  - Outside INJECT, mask = 0.
- IDLE, on arm_i:
  - mode 0 with lo_i > hi_i or hi_i >= PAGE_BYTES: pulse cfg_err_o, stay IDLE.
  - Otherwise latch configuration, load LFSR, clear table and inj_cnt_o, go to GEN.
- GEN, one LFSR step per cycle (Galois, polynomial x^32+x^22+x^2+x+1):
  - cand = lfsr[ADDR_W-1:0] masked to ceil(log2(span)) bits, span = hi-lo+1.
  - If cand < span, write entry (lo+cand, lfsr[31 -: $clog2(DATA_W)]). Otherwise retry (rejection sampling).
  - When the entry count reaches min(fault_num_i, MAX_FAULTS), go to ARMED. fault_num_i = 0 goes to ARMED after 1 cycle with an empty table.
  - Directed mode writes the single entry (dir_byte_i, dir_bit_i) in 1 cycle.
- ARMED: wait for s_valid_i & s_sop_i; that byte is index 0 and enters INJECT.
- INJECT:
  - Byte index increments on each valid byte.
  - inj_cnt_o increments on each modified byte.
  - After byte PAGE_BYTES-1: pulse done_o, go to IDLE.
  - A new s_sop_i mid-page restarts the index at 0; table and count are kept.
- arm_i outside IDLE is ignored.
- Identical seed and configuration give an identical table.

Optional Feature:
- FI_STUCK_AT_EN defined:
  - Adds input stuck_val_i [1].
  - Matched bits are forced to stuck_val_i instead of flipped.
  - Duplicate entries do not cancel.
  - m_fault_o and inj_cnt_o count only bytes whose value actually changed.
- FI_STUCK_AT_EN undefined: flip-only behaviour; port absent.

Test Plan:
- Directed: mode=1, byte 5, bit 3. Arm, stream 2112 bytes of 8'hFF with sop on the first.
  - Output byte 5 = 8'hF7 with m_fault_o=1; all other bytes 8'hFF.
  - inj_cnt_o=1; done_o pulses 1 cycle after the last m_valid_o.
- Random: seed 32'hACE1, fault_num 16, window 1024..2047.
  - All modified bytes lie in 1024..2047.
  - Sum of popcount(out XOR in) is 16 minus 2 per duplicate pair.
  - A re-run with the same seed gives an identical diff.
- fault_num 0, arm, stream a page: output equals input, inj_cnt_o=0, done_o pulses.
- lo=100, hi=50, mode 0, arm: cfg_err_o pulses; armed_o stays 0; data passes unchanged.
- Assert HRESETn low mid-INJECT at byte 700: outputs 0 immediately, no done_o. A following arm works normally.
- FI_STUCK_AT_EN with stuck_val_i=0: directed byte 0, bit 0, input 8'h00 -> output unchanged, m_fault_o=0, inj_cnt_o=0.
